// File: rtl/serial_digit_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_e        : controller states (IDLE, RUN)
//   num_digits()   : number of DIGIT-wide slices in a WIDTH-bit operand
//   counter_width(): digit counter width, $clog2 of the digit count, at least 1
package serial_digit_adder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Guarded so an illegal DIGIT does not turn into a divide-by-zero
    // before the elaboration check in the top can report it.
    function automatic int num_digits(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end else begin
            return width / digit;
        end
    endfunction

    function automatic int counter_width(input int n_digits);
        int w;
        w = $clog2(n_digits);
        if (w < 1) begin
            return 1;
        end else begin
            return w;
        end
    endfunction

endpackage

// File: rtl/serial_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder built from the gate-level full-adder
// cell (also defined here as full_adder_cell).
// digit_adder ports:
//   a, b      : DIGIT-bit operand slices
//   cin       : carry into bit 0 of the slice
//   s         : DIGIT-bit sum slice
//   cout      : carry out of the slice MSB
//   cin_msb   : carry into the slice MSB (used for signed overflow)
// full_adder_cell ports: a, b, ci in; s, co out.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p_s;

    assign p_s = a ^ b;
    assign s   = p_s ^ ci;
    assign co  = (a & b) | (ci & p_s);
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             cin_msb
);
    logic [DIGIT:0] carry_s;

    assign carry_s[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_bit
            full_adder_cell u_fa (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (carry_s[gi]),
                .s  (s[gi]),
                .co (carry_s[gi+1])
            );
        end
    endgenerate

    assign cout    = carry_s[DIGIT];
    assign cin_msb = carry_s[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock,
// least-significant digit first, with a start/busy/done handshake.
// Optional feature: define SERIAL_DIGIT_ADDER_SUB_EN to add a 'sub' input
// that turns the operation into a - b (B inverted, carry forced to 1).
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request; sampled only while busy=0
//   a, b         : operands, captured on the accepting edge
//   carry_in     : carry into bit 0, captured on the accepting edge
//   sub          : (SERIAL_DIGIT_ADDER_SUB_EN only) subtract select
//   busy         : operation in progress (NUM_DIGITS cycles)
//   done         : one-cycle result-valid pulse
//   sum          : result, held until the next done
//   carry_out    : carry out of bit WIDTH-1 (1 = no borrow when subtracting)
//   overflow     : signed overflow, carry into MSB XOR carry out of MSB
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int CNT_W      = counter_width(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("serial_digit_adder: DIGIT must be at least 1");
        end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
            $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    state_e             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   res_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_out_r;
    logic               overflow_r;

    logic [WIDTH-1:0]   b_load_s;
    logic               cin_load_s;
    logic [DIGIT-1:0]   dsum_s;
    logic               dcout_s;
    logic               dcmsb_s;
    logic [WIDTH-1:0]   res_next_s;

    // Operand B / carry values loaded on the accepting edge (inverted B for subtract).
    always_comb begin
        b_load_s   = b;
        cin_load_s = carry_in;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        if (sub) begin
            b_load_s   = ~b;
            cin_load_s = 1'b1;
        end else begin
            b_load_s   = b;
            cin_load_s = carry_in;
        end
`endif
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a       (a_r[DIGIT-1:0]),
        .b       (b_r[DIGIT-1:0]),
        .cin     (carry_r),
        .s       (dsum_s),
        .cout    (dcout_s),
        .cin_msb (dcmsb_s)
    );

    // New digit enters at the top; written as shift/OR so DIGIT == WIDTH
    // needs no special-cased slice.
    assign res_next_s = (res_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));

    // Controller, operand shift registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            res_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b_load_s;
                        carry_r <= cin_load_s;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    res_r   <= res_next_s;
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dcout_s;
                    cnt_r   <= cnt_r + CNT_W'(1'b1);
                    if (cnt_r == LAST_CNT) begin
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        sum_r       <= res_next_s;
                        carry_out_r <= dcout_s;
                        overflow_r  <= dcmsb_s ^ dcout_s;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed self-checking bench for serial_digit_adder (WIDTH=16, DIGIT=4).
// Subtract vectors run only when SERIAL_DIGIT_ADDER_SUB_EN is defined.
module tb_serial_digit_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int checks;
    int errors;

    serial_digit_adder #(
        .WIDTH (16),
        .DIGIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One operation: drive at a falling edge, watch latency/busy, check result.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input logic [15:0] es, input logic ec,
                         input logic eo, input string tag);
        int edges;
        int busy_cnt;
        @(negedge clk);
        a = av; b = bv; carry_in = cv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv; carry_in = ~cv; sub = ~sv;
        edges = 0;
        busy_cnt = 0;
        forever begin
            if (busy) busy_cnt++;
            if (done || edges >= 20) break;
            @(negedge clk);
            edges++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_latency"}, edges, 32'd4);
        chk({tag, "_busy_cycles"}, busy_cnt, 32'd4);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({tag, "_cout_ovf"}, {30'd0, carry_out, overflow}, {30'd0, ec, eo});
        @(negedge clk);
        chk({tag, "_done_drop"}, {15'd0, done, sum}, {15'd0, 1'b0, es});
    endtask

    initial begin
        int first_done;
        int second_done;
        logic [15:0] sum1;
        logic [15:0] sum2;
        logic saw_done;

        checks = 0; errors = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0; carry_in = 1'b0; sub = 1'b0;
        #22;
        chk("reset_outputs", {11'd0, busy, done, carry_out, overflow, sum}, 32'd0);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_1234_4321");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_ffff_0001");
        do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "add_cin_only");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_7fff_0001");
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "add_8000_8000");

        // start held for 10 cycles while a changes: the first value is used,
        // and the value present on the done cycle starts the second op.
        first_done = -1; second_done = -1; sum1 = 16'd0; sum2 = 16'd0;
        b = 16'h0001; carry_in = 1'b0; sub = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                if (first_done < 0) begin
                    first_done = i; sum1 = sum;
                end else begin
                    second_done = i; sum2 = sum;
                end
            end
            if (i < 10) begin
                a = 16'h0010 + 16'(i);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("held_first_done_cycle", first_done, 32'd5);
        chk("held_first_sum", {16'd0, sum1}, 32'h0000_0011);
        chk("held_second_done_cycle", second_done, 32'd10);
        chk("held_second_sum", {16'd0, sum2}, 32'h0000_0016);

        // Reset pulse while digit 2 is pending: abort, outputs cleared, no done.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {11'd0, busy, done, carry_out, overflow, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrun_no_done_or_busy", {31'd0, saw_done}, 32'd0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_after_reset");

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_0005_0007");
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_8000_0001");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
